// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   UART receive frame engine. Oversamples the serial line, deserializes
//   LSB-first data, checks an optional parity bit and validates the stop bit.
//   Each frame ends with exactly one single-cycle status pulse.
//
// Parameters
//   width       data bits per frame (>= 1)
//   oversample  clk cycles per bit (even, >= 4)
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active-high
//   rx_in          serial line, idle high, already synchronized
//   parity_enable  1 = frame carries a parity bit after the data
//   parity_type    0 = even (expected = ^data), 1 = odd (expected = ~^data)
//   data_out       last good word, held between frames
//   data_valid     pulse: word accepted
//   parity_error   pulse: parity mismatch
//   stop_error     pulse: stop bit sampled low (wins over parity_error)
//   busy           high while a frame is in progress
//
// Optional feature (macro UART_RX_MAJORITY_VOTE_EN)
//   Defined: each bit is the 2-of-3 majority of the samples at
//   oversample/2-1, oversample/2 and oversample/2+1; the decision is taken at
//   oversample/2+1. Undefined: single sample at oversample/2.

module uart_rx_frame #(
    parameter int unsigned width      = 8,
    parameter int unsigned oversample = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_in,
    input  logic             parity_enable,
    input  logic             parity_type,
    output logic [width-1:0] data_out,
    output logic             data_valid,
    output logic             parity_error,
    output logic             stop_error,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(oversample);
    localparam int unsigned BitW = (width > 1) ? $clog2(width) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   edge_cnt_q;
    logic [BitW-1:0]   bit_cnt_q;
    logic [width-1:0]  shift_q;
    logic [width-1:0]  data_out_q;
    logic              par_en_q;
    logic              par_type_q;
    logic              par_err_q;
    logic              data_valid_q;
    logic              parity_error_q;
    logic              stop_error_q;
    logic              busy_q;

    logic              bit_val;
    logic              at_decide;
    logic              at_wrap;
    logic              last_bit;
    logic              exp_parity;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int unsigned DecideCnt = oversample / 2 + 1;

    // early_q[0]: sample at oversample/2-1, early_q[1]: sample at oversample/2
    logic [1:0] early_q;

    always_comb begin
        bit_val = (early_q[0] & early_q[1]) | (early_q[0] & rx_in) | (early_q[1] & rx_in);
    end
`else
    localparam int unsigned DecideCnt = oversample / 2;

    always_comb begin
        bit_val = rx_in;
    end
`endif

    always_comb begin
        at_decide  = (edge_cnt_q == CntW'(DecideCnt));
        at_wrap    = (edge_cnt_q == CntW'(oversample - 1));
        last_bit   = (bit_cnt_q == BitW'(width - 1));
        exp_parity = par_type_q ? ~^shift_q : ^shift_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            data_out_q     <= '0;
            par_en_q       <= 1'b0;
            par_type_q     <= 1'b0;
            par_err_q      <= 1'b0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
            busy_q         <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
            early_q        <= '0;
`endif
        end else begin
            // Status outputs are single-cycle pulses.
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;

            if (state_q == StIdle) begin
                edge_cnt_q <= '0;
                if (!rx_in) begin
                    // Frame options are frozen for the whole frame here.
                    state_q    <= StStart;
                    bit_cnt_q  <= '0;
                    par_en_q   <= parity_enable;
                    par_type_q <= parity_type;
                    par_err_q  <= 1'b0;
                    busy_q     <= 1'b1;
                end
            end else begin
                if (at_wrap) begin
                    edge_cnt_q <= '0;
                end else begin
                    edge_cnt_q <= edge_cnt_q + CntW'(1);
                end

`ifdef UART_RX_MAJORITY_VOTE_EN
                if (edge_cnt_q == CntW'(oversample / 2 - 1)) begin
                    early_q[0] <= rx_in;
                end
                if (edge_cnt_q == CntW'(oversample / 2)) begin
                    early_q[1] <= rx_in;
                end
`endif

                case (state_q)
                    StStart: begin
                        if (at_decide && bit_val) begin
                            // Start bit did not hold low: treat as a glitch.
                            state_q    <= StIdle;
                            edge_cnt_q <= '0;
                            busy_q     <= 1'b0;
                        end else if (at_wrap) begin
                            state_q <= StData;
                        end
                    end
                    StData: begin
                        if (at_decide) begin
                            shift_q <= {bit_val, shift_q[width-1:1]};
                        end
                        if (at_wrap) begin
                            if (last_bit) begin
                                bit_cnt_q <= '0;
                                state_q   <= par_en_q ? StParity : StStop;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BitW'(1);
                            end
                        end
                    end
                    StParity: begin
                        if (at_decide) begin
                            par_err_q <= (bit_val != exp_parity);
                        end
                        if (at_wrap) begin
                            state_q <= StStop;
                        end
                    end
                    StStop: begin
                        // Leave at the decision point so back-to-back frames
                        // can start during the remainder of the stop bit.
                        if (at_decide) begin
                            state_q    <= StIdle;
                            edge_cnt_q <= '0;
                            busy_q     <= 1'b0;
                            if (!bit_val) begin
                                stop_error_q <= 1'b1;
                            end else if (par_err_q) begin
                                parity_error_q <= 1'b1;
                            end else begin
                                data_valid_q <= 1'b1;
                                data_out_q   <= shift_q;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        data_out     = data_out_q;
        data_valid   = data_valid_q;
        parity_error = parity_error_q;
        stop_error   = stop_error_q;
        busy         = busy_q;
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame
//   Directed bench for uart_rx_frame (width=8, oversample=8). Frames are
//   driven bit by bit; a monitor records busy edges and status pulses with
//   their cycle numbers, which are compared against hand-computed values.

module tb_uart_rx_frame;

    localparam int W  = 8;
    localparam int OS = 8;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int MV = 1;
`else
    localparam int MV = 0;
`endif

    localparam logic [2:0] KindValid = 3'b100;
    localparam logic [2:0] KindPerr  = 3'b010;
    localparam logic [2:0] KindSerr  = 3'b001;

    logic         clk;
    logic         rst;
    logic         rx_in;
    logic         parity_enable;
    logic         parity_type;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         parity_error;
    logic         stop_error;
    logic         busy;

    uart_rx_frame #(
        .width      (W),
        .oversample (OS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_in         (rx_in),
        .parity_enable (parity_enable),
        .parity_type   (parity_type),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .stop_error    (stop_error),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;

    // Monitor state
    int           pulse_cnt  = 0;
    int           pulse_cyc  = -1;
    logic [2:0]   pulse_kind = 3'b000;
    logic [W-1:0] pulse_data = '0;
    int           busy_rise  = -1;
    int           busy_fall  = -1;
    logic         busy_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy && !busy_prev) busy_rise = cyc;
        if (!busy && busy_prev) busy_fall = cyc;
        busy_prev = busy;
        if (data_valid || parity_error || stop_error) begin
            pulse_cnt  = pulse_cnt + 1;
            pulse_cyc  = cyc;
            pulse_kind = {data_valid, parity_error, stop_error};
            pulse_data = data_out;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; holds the bit for one full bit period.
    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (OS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input bit pen, input bit pbit,
                              input bit sbit, input bit toggle);
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < W; i++) begin
            if (toggle && i == 3) parity_type = ~parity_type;
            drive_bit(d[i]);
        end
        if (toggle) parity_type = ~parity_type;
        if (pen) drive_bit(pbit);
        drive_bit(sbit);
        rx_in = 1'b1;
    endtask

    function automatic int exp_pulse(input bit pen);
        return t0 + 2 + OS * (1 + W + int'(pen)) + OS / 2 + MV;
    endfunction

    int base;

    initial begin
        rst           = 1'b1;
        rx_in         = 1'b1;
        parity_enable = 1'b0;
        parity_type   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_data", 32'(data_out), 32'h00);
        check_eq("reset_pulses", 32'({data_valid, parity_error, stop_error}), 32'd0);
        repeat (4) @(negedge clk);

        // 0xA5, no parity
        base = pulse_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("a5_busy_rise", 32'(busy_rise), 32'(t0 + 1));
        check_eq("a5_busy_fall", 32'(busy_fall), 32'(t0 + 78 + MV));
        check_eq("a5_pulse_cyc", 32'(pulse_cyc), 32'(exp_pulse(1'b0)));
        check_eq("a5_kind", 32'(pulse_kind), 32'(KindValid));
        check_eq("a5_data", 32'(pulse_data), 32'hA5);
        check_eq("a5_count", 32'(pulse_cnt - base), 32'd1);
        repeat (4) @(negedge clk);

        // Even parity, 0x07 with correct parity bit 1
        parity_enable = 1'b1;
        parity_type   = 1'b0;
        base = pulse_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("p07_pulse_cyc", 32'(pulse_cyc), 32'(t0 + 86 + MV));
        check_eq("p07_kind", 32'(pulse_kind), 32'(KindValid));
        check_eq("p07_data", 32'(data_out), 32'h07);
        check_eq("p07_count", 32'(pulse_cnt - base), 32'd1);
        repeat (4) @(negedge clk);

        // Even parity, 0x07 with wrong parity bit 0
        base = pulse_cnt;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("p07bad_kind", 32'(pulse_kind), 32'(KindPerr));
        check_eq("p07bad_cyc", 32'(pulse_cyc), 32'(t0 + 86 + MV));
        check_eq("p07bad_count", 32'(pulse_cnt - base), 32'd1);
        repeat (4) @(negedge clk);

        // Odd parity, 0x00 with parity bit 1, type toggled mid-frame
        parity_type = 1'b1;
        base = pulse_cnt;
        send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("odd00_kind", 32'(pulse_kind), 32'(KindValid));
        check_eq("odd00_data", 32'(data_out), 32'h00);
        check_eq("odd00_count", 32'(pulse_cnt - base), 32'd1);
        repeat (4) @(negedge clk);

        // Prime data_out with a nonzero word so hold-on-error is visible
        parity_type = 1'b0;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);

        // 0x3C even parity, bad parity bit 1, stop bit 0 -> stop_error only
        base = pulse_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("stop_kind", 32'(pulse_kind), 32'(KindSerr));
        check_eq("stop_cyc", 32'(pulse_cyc), 32'(t0 + 86 + MV));
        check_eq("stop_data_held", 32'(data_out), 32'h07);
        repeat (20) @(negedge clk);
        // Line low at the pulse cycle restarts a frame that then glitches out
        check_eq("stop_count", 32'(pulse_cnt - base), 32'd1);
        check_eq("stop_busy_after", 32'(busy), 32'd0);

        // Start glitch: low for 2 cycles then high
        parity_enable = 1'b0;
        base = pulse_cnt;
        t0 = cyc;
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("glitch_rise", 32'(busy_rise), 32'(t0 + 1));
        check_eq("glitch_fall", 32'(busy_fall), 32'(t0 + 6 + MV));
        check_eq("glitch_count", 32'(pulse_cnt - base), 32'd0);
        check_eq("glitch_busy", 32'(busy), 32'd0);

        // Back-to-back 0x11 then 0x22
        base = pulse_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("b2b1_data", 32'(pulse_data), 32'h11);
        check_eq("b2b1_kind", 32'(pulse_kind), 32'(KindValid));
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("b2b2_data", 32'(pulse_data), 32'h22);
        check_eq("b2b2_cyc", 32'(pulse_cyc), 32'(exp_pulse(1'b0)));
        check_eq("b2b_count", 32'(pulse_cnt - base), 32'd2);
        repeat (4) @(negedge clk);

        // Reset during bit 4 of an all-ones frame
        base = pulse_cnt;
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx_in = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_data", 32'(data_out), 32'h00);
        check_eq("rst_mid_pulses", 32'({data_valid, parity_error, stop_error}), 32'd0);
        repeat (100) @(negedge clk);
        check_eq("rst_mid_no_pulse", 32'(pulse_cnt - base), 32'd0);

        // Frame after reset
        base = pulse_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("p5a_kind", 32'(pulse_kind), 32'(KindValid));
        check_eq("p5a_data", 32'(data_out), 32'h5A);
        check_eq("p5a_count", 32'(pulse_cnt - base), 32'd1);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receive-side frame engine, the counterpart to the team's parameterized TX path (serializer plus parity_calc).
- Oversamples a serial line and deserializes LSB-first data.
- Checks the optional parity bit using the same type encoding as TX, and validates the stop bit.
- Presents each received word with one-cycle status pulses to the downstream consumer.

Parameters:
- width, 8: data bits per frame (≥1).
- oversample, 8: clk cycles per bit; even, ≥4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- rx_in  input  1  serial line, idle high; synchronized upstream, so the block has no internal synchronizer.
- parity_enable  input  1  1 = frame carries a parity bit after the data.
- parity_type  input  1  0 = even (expected bit = ^data), 1 = odd (expected bit = ~^data).
- data_out  output  width  last good word; holds its value between frames.
- data_valid  output  1  one-cycle pulse: word accepted.
- parity_error  output  1  one-cycle pulse: parity mismatch.
- stop_error  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset: synchronous and active-high. The whole block is reset only by rst; there are no other reset sources.
- Reset values: state = IDLE; data_out = 0; data_valid, parity_error, stop_error and busy all = 0; internal counters and shift register = 0.
- Reset mid-frame: abandons the frame with no pulse; the next start edge is searched from IDLE.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - rx_in == 0 in cycle T0 → START at T0+1 with edge_cnt = 0.
  - At T0, parity_enable and parity_type are latched; mid-frame changes on those ports are ignored.
- Counting: edge_cnt increments every non-IDLE cycle and wraps at oversample-1. On a wrap, the state moves to the next bit.
- Sample point: edge_cnt == oversample/2; bit_value = rx_in.
- START: sampled 1 → glitch; return to IDLE immediately with no pulse. Sampled 0 → continue; at wrap → DATA.
- DATA:
  - Sampled bits are shifted in LSB first.
  - bit_cnt counts 0..width-1; after bit width-1 wraps → PARITY if the latched enable = 1, else STOP.
- PARITY: the sampled bit is compared with the expected bit computed from the received word using the latched type.
- STOP:
  - At the sample point, the state goes to IDLE the next cycle; the block does not wait for the full stop bit, which permits back-to-back frames.
  - In that next cycle, exactly one outcome is pulsed:
    - stop bit 0 → stop_error = 1 (takes priority; parity_error stays 0).
    - else parity mismatch → parity_error = 1.
    - else data_valid = 1 and data_out updates in the same cycle.
- data_out is never updated on an error frame.
- busy: 1 from the START entry cycle through the STOP sample cycle; 0 in the pulse cycle.
- Latency: stop sample cycle = T0 + 1 + oversample*(1 + width + P) + oversample/2, where P = latched enable. The pulse appears 1 cycle later.
- Line stuck low (break):
  - The frame ends with stop_error.
  - IDLE then sees 0 and starts a new frame immediately, so a stop_error pulse repeats every frame until the line returns high.
- A new start edge arriving in the pulse cycle is accepted; the pulse and START entry do not conflict.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Each bit is resolved as the 2-of-3 majority of samples at edge_cnt = oversample/2-1, oversample/2 and oversample/2+1.
  - The decision is taken at oversample/2+1, so the pulse and the busy fall are 1 cycle later than the latency formula.
  - The START glitch check also uses the majority value.
- Undefined: single sample at oversample/2, exactly as described in Behaviour.

Test Plan:
- width=8, oversample=8, parity off; rst, then frame 0xA5 with start edge at T0 → busy high T0+1..T0+77; data_valid pulse at T0+78; data_out = 0xA5.
- Parity on, even; frame 0x07 with parity bit 1 → data_valid at T0+86. Same frame with parity bit 0 → parity_error pulse; data_out keeps its prior value.
- Parity on, odd; frame 0x00 with parity bit 1 → data_valid. Toggle parity_type mid-frame → no effect on the result.
- Frame 0x3C with stop bit 0 and a bad parity bit → stop_error only; parity_error = 0 and data_valid = 0.
- rx_in low for 2 cycles then high → START sample = 1 → return to IDLE; no pulse, busy low afterwards. Then two back-to-back frames 0x11, 0x22 → two data_valid pulses with the correct data.
- Assert rst for 1 cycle during bit 4 of a frame → all outputs 0 the next cycle, no pulse. A subsequent frame 0x5A is received correctly.
